sum_accumulator: RTL and testbench
==================================

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

Interface
REQ-001 Parameter WIDTH, default 8: operand width of the upstream adder; i_result is WIDTH+1 bits.
REQ-002 Parameter COUNT, default 4: adder results summed per batch; legal range 1..256.
REQ-003 Derived constant ACC_W = WIDTH+1+$clog2(COUNT+1): accumulator and o_sum width; it cannot overflow.
REQ-004 i_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 i_rst  input  1  reset; synchronous and active-high.
REQ-006 i_valid  input  1  upstream result valid.
REQ-007 i_result  input  WIDTH+1  unsigned {carry, sum} word from the adder stage.
REQ-008 o_ready  output  1  block accepts i_result this cycle.
REQ-009 o_valid  output  1  batch sum available.
REQ-010 o_sum  output  ACC_W  batch sum.
REQ-011 o_count  output  $clog2(COUNT+1)  number of results contained in o_sum.
REQ-012 i_ready  input  1  downstream accepts o_sum.

Function
REQ-013 The block SHALL use a two-state FSM: ACCUM and HOLD.
REQ-014 In ACCUM, o_ready SHALL be 1 and o_valid SHALL be 0.
REQ-015 In HOLD, o_valid SHALL be 1 and o_ready SHALL equal i_ready (combinational pass-through).
REQ-016 An input transfer is i_valid && o_ready; an output transfer is o_valid && i_ready.
REQ-017 On an input transfer in ACCUM, the block SHALL set acc <= acc + zero-extended i_result and cnt <= cnt+1.
REQ-018 If that transfer makes cnt equal COUNT, the block SHALL enter HOLD next cycle with o_sum = the final sum and o_count = COUNT (latency 1 cycle from the last accepted input).
REQ-019 In HOLD, o_sum and o_count SHALL be stable until the output transfer.
REQ-020 An output transfer without a simultaneous input transfer SHALL return the FSM to ACCUM with acc=0 and cnt=0.
REQ-021 Simultaneous output and input transfer in HOLD SHALL start the next batch: acc <= i_result, cnt <= 1; the FSM goes to ACCUM, or stays in HOLD if COUNT=1.
REQ-022 With COUNT=1, each accepted input SHALL appear at o_sum one cycle later, and full throughput of one result per cycle SHALL be sustained while i_ready=1.
REQ-023 No input SHALL be dropped or double-counted under any i_valid/i_ready pattern.
REQ-024 Maximum input (all ones, 2^(WIDTH+1)-1) repeated COUNT times SHALL produce the exact sum with no wrap.

Reset
REQ-025 While i_rst=1 at a clock edge, the block SHALL set FSM=ACCUM, acc=0, cnt=0, o_valid=0, o_sum=0, o_count=0.
REQ-026 A reset mid-batch or during HOLD SHALL discard the partial or pending sum without emitting it.
REQ-027 o_ready SHALL be 0 while i_rst=1.

Configuration
REQ-028 Macro SUM_ACCUMULATOR_FLUSH_EN, when defined, SHALL add port i_flush (input, 1 bit).
REQ-029 With the macro defined, i_flush=1 in ACCUM with cnt>0, or with an input transfer in the same cycle, SHALL close the batch early. The FSM goes to HOLD with o_count equal to the included results, and any same-cycle input is included.
REQ-030 With the macro defined, i_flush with cnt=0 and no input transfer SHALL be ignored, and i_flush in HOLD SHALL be ignored.
REQ-031 Without the macro, the i_flush port and its logic SHALL be absent, and batches close only at COUNT.

Structure
REQ-032 Package sum_accumulator_pkg SHALL hold the FSM state enum (ACCUM, HOLD) and an acc_width(WIDTH, COUNT) constant function.
REQ-033 The block SHALL be a single module with no sub-modules; the adder itself stays a separate upstream instance.

Verification
REQ-034 WIDTH=8, COUNT=4, inputs 1,2,3,4 back-to-back, i_ready=1 -> one output o_sum=10, o_count=4, asserted 1 cycle after the 4th input.
REQ-035 WIDTH=8, COUNT=4, four inputs of 511 -> o_sum=2044, no wrap.
REQ-036 i_ready=0 for 5 cycles in HOLD -> o_ready=0, o_sum held. Then i_ready=1 with i_valid=1, i_result=7 -> next batch starts at 7, with no lost transfer.
REQ-037 COUNT=1, continuous inputs 5,6,7 with i_ready=1 -> outputs 5,6,7 on consecutive cycles.
REQ-038 i_rst pulse after 2 of 4 inputs, then inputs 1,1,1,1 -> o_sum=4, and the partial batch is never emitted.
REQ-039 SUM_ACCUMULATOR_FLUSH_EN defined: inputs 3,4, then i_flush alone -> o_sum=7, o_count=2. A following i_flush with no input -> no output.

Source files
------------

// File: rtl/sum_accumulator_pkg.sv
// sum_accumulator_pkg: FSM state type and accumulator width helper for sum_accumulator
package sum_accumulator_pkg;
  typedef enum logic [0:0] {ACCUM = 1'b0, HOLD = 1'b1} state_t;
  function automatic int acc_width(input int width, input int count);
    return width + 1 + $clog2(count + 1);
  endfunction
endpackage

// File: rtl/sum_accumulator.sv
// sum_accumulator: sums COUNT adder results per batch, optional early close via SUM_ACCUMULATOR_FLUSH_EN
module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int COUNT = 4,
  localparam int ACC_W = acc_width(WIDTH, COUNT),
  localparam int CNT_W = $clog2(COUNT + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH:0]   i_result,
`ifdef SUM_ACCUMULATOR_FLUSH_EN
  input  logic             i_flush,
`endif
  output logic             o_ready,
  output logic             o_valid,
  output logic [ACC_W-1:0] o_sum,
  output logic [CNT_W-1:0] o_count,
  input  logic             i_ready
);
  state_t r_state;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic w_in, w_out, w_close;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [ACC_W-1:0] w_acc_add;
  assign o_valid   = r_state == HOLD;
  assign o_ready   = !i_rst && (r_state == ACCUM || i_ready);
  assign o_sum     = r_acc;
  assign o_count   = r_cnt;
  assign w_in      = i_valid && o_ready;
  assign w_out     = o_valid && i_ready;
  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_acc_add = r_acc + ACC_W'(i_result);
`ifdef SUM_ACCUMULATOR_FLUSH_EN
  assign w_close = (w_in && w_cnt_inc == CNT_W'(COUNT)) || (i_flush && (w_in || r_cnt != '0));
`else
  assign w_close = w_in && w_cnt_inc == CNT_W'(COUNT);
`endif
  // accumulate in ACCUM; in HOLD keep the result until taken, chaining the next batch on a same-cycle input
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (r_state == ACCUM) begin
      if (w_in) begin
        r_acc <= w_acc_add;
        r_cnt <= w_cnt_inc;
      end
      if (w_close) r_state <= HOLD;
    end else if (w_out) begin
      r_acc   <= w_in ? ACC_W'(i_result) : '0;
      r_cnt   <= w_in ? CNT_W'(1) : '0;
      r_state <= (w_in && COUNT == 1) ? HOLD : ACCUM;
    end
  end
endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: directed vectors plus random traffic against a batch-queue reference model
module tb_sum_accumulator;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  logic v4, rdy4, ordy4, ov4;
  logic [8:0] r4;
  logic [11:0] s4;
  logic [2:0] c4;
  logic v1, rdy1, ordy1, ov1;
  logic [8:0] r1;
  logic [9:0] s1;
  logic [0:0] c1;
`ifdef SUM_ACCUMULATOR_FLUSH_EN
  logic fl4, fl1;
`endif
  int tests = 0;
  int fails = 0;
  sum_accumulator #(.WIDTH(8), .COUNT(4)) u4 (
    .i_clk(clk), .i_rst(rst), .i_valid(v4), .i_result(r4),
`ifdef SUM_ACCUMULATOR_FLUSH_EN
    .i_flush(fl4),
`endif
    .o_ready(ordy4), .o_valid(ov4), .o_sum(s4), .o_count(c4), .i_ready(rdy4));
  sum_accumulator #(.WIDTH(8), .COUNT(1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_valid(v1), .i_result(r1),
`ifdef SUM_ACCUMULATOR_FLUSH_EN
    .i_flush(fl1),
`endif
    .o_ready(ordy1), .o_valid(ov1), .o_sum(s1), .o_count(c1), .i_ready(rdy1));
  typedef struct {
    logic v;
    int r;
    logic rdy;
    logic ev;
    logic erdy;
    int esum;
    int ecnt;
  } vec_t;
  vec_t tbl[$];
  bit m_pend[2];
  longint m_sum[2];
  longint m_cnt[2];
  int unsigned bq0[$];
  int unsigned bq1[$];
  task automatic chk(input string n, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic model_reset();
    m_pend = '{0, 0};
    bq0.delete();
    bq1.delete();
  endtask
  task automatic model_cycle(input int d, input int cmax, input logic v, input int r, input logic rdy,
                             input logic av, input logic ardy, input longint asum, input longint acnt);
    bit xin, xout;
    longint s;
    int n;
    chk($sformatf("rnd%0d valid", d), longint'(av), longint'(m_pend[d]));
    chk($sformatf("rnd%0d ready", d), longint'(ardy), longint'(!m_pend[d] || rdy));
    if (m_pend[d]) begin
      chk($sformatf("rnd%0d sum", d), asum, m_sum[d]);
      chk($sformatf("rnd%0d count", d), acnt, m_cnt[d]);
    end
    xout = m_pend[d] && rdy;
    xin  = v && (!m_pend[d] || rdy);
    if (xout) m_pend[d] = 0;
    if (xin) begin
      if (d == 0) bq0.push_back(r); else bq1.push_back(r);
      n = (d == 0) ? bq0.size() : bq1.size();
      if (n == cmax) begin
        s = 0;
        for (int i = 0; i < n; i++) s += (d == 0) ? bq0[i] : bq1[i];
        m_pend[d] = 1;
        m_sum[d]  = s;
        m_cnt[d]  = n;
        if (d == 0) bq0.delete(); else bq1.delete();
      end
    end
  endtask
  task automatic drive4(input logic v, input int r, input logic rdy);
    v4 = v;
    r4 = 9'(r);
    rdy4 = rdy;
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    v4 = 1'b1; r4 = 9'd5; rdy4 = 1'b1;
    v1 = 1'b1; r1 = 9'd5; rdy1 = 1'b1;
    #1;
    chk("rst ready4", longint'(ordy4), 0);
    chk("rst ready1", longint'(ordy1), 0);
    tick();
    rst = 1'b0;
    v4 = 1'b0; v1 = 1'b0;
    #1;
  endtask
  initial begin
    rst = 1'b1;
    v4 = 0; r4 = 0; rdy4 = 0; v1 = 0; r1 = 0; rdy1 = 0;
`ifdef SUM_ACCUMULATOR_FLUSH_EN
    fl4 = 0; fl1 = 0;
`endif
    tick();
    do_reset();
    chk("reset valid", longint'(ov4), 0);
    chk("reset sum", longint'(s4), 0);
    chk("reset count", longint'(c4), 0);
    tbl.push_back('{1, 1, 1, 0, 1, 0, 0});
    tbl.push_back('{1, 2, 1, 0, 1, 0, 0});
    tbl.push_back('{1, 3, 1, 0, 1, 0, 0});
    tbl.push_back('{1, 4, 1, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 1, 1, 1, 10, 4});
    for (int i = 0; i < 4; i++) tbl.push_back('{1, 511, 1, 0, 1, 0, 0});
    for (int i = 0; i < 5; i++) tbl.push_back('{1, 99, 0, 1, 0, 2044, 4});
    tbl.push_back('{1, 7, 1, 1, 1, 2044, 4});
    for (int i = 0; i < 3; i++) tbl.push_back('{1, 1, 1, 0, 1, 0, 0});
    tbl.push_back('{0, 0, 1, 1, 1, 10, 4});
    tbl.push_back('{0, 0, 1, 0, 1, 0, 0});
    foreach (tbl[k]) begin
      drive4(tbl[k].v, tbl[k].r, tbl[k].rdy);
      chk($sformatf("vec%0d valid", k), longint'(ov4), longint'(tbl[k].ev));
      chk($sformatf("vec%0d ready", k), longint'(ordy4), longint'(tbl[k].erdy));
      if (tbl[k].ev) begin
        chk($sformatf("vec%0d sum", k), longint'(s4), tbl[k].esum);
        chk($sformatf("vec%0d count", k), longint'(c4), tbl[k].ecnt);
      end
      tick();
    end
    drive4(1, 1, 1); tick();
    drive4(1, 1, 1); tick();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive4(1, 1, 1);
      chk($sformatf("midrst no emit %0d", i), longint'(ov4), 0);
      tick();
    end
    drive4(0, 0, 1);
    chk("midrst valid", longint'(ov4), 1);
    chk("midrst sum", longint'(s4), 4);
    chk("midrst count", longint'(c4), 4);
    tick();
    rdy1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      v1 = (i < 3);
      r1 = 9'(5 + i);
      #1;
      chk($sformatf("c1 valid %0d", i), longint'(ov1), longint'(i >= 1 && i <= 3));
      chk($sformatf("c1 ready %0d", i), longint'(ordy1), 1);
      if (i >= 1 && i <= 3) chk($sformatf("c1 sum %0d", i), longint'(s1), 4 + i);
      tick();
    end
    v1 = 1'b0;
`ifdef SUM_ACCUMULATOR_FLUSH_EN
    do_reset();
    drive4(1, 3, 1); tick();
    drive4(1, 4, 1); tick();
    fl4 = 1'b1;
    drive4(0, 0, 1);
    chk("flush pre valid", longint'(ov4), 0);
    tick();
    fl4 = 1'b0;
    drive4(0, 0, 1);
    chk("flush valid", longint'(ov4), 1);
    chk("flush sum", longint'(s4), 7);
    chk("flush count", longint'(c4), 2);
    tick();
    fl4 = 1'b1;
    drive4(0, 0, 1);
    tick();
    fl4 = 1'b0;
    drive4(0, 0, 1);
    chk("flush empty ignored", longint'(ov4), 0);
    tick();
    fl4 = 1'b1;
    drive4(1, 9, 1);
    tick();
    fl4 = 1'b0;
    drive4(0, 0, 1);
    chk("flush same-cycle valid", longint'(ov4), 1);
    chk("flush same-cycle sum", longint'(s4), 9);
    chk("flush same-cycle count", longint'(c4), 1);
    tick();
`endif
    do_reset();
    model_reset();
    for (int i = 0; i < 400; i++) begin
      v4 = 1'($urandom_range(0, 1));
      r4 = ($urandom_range(0, 3) == 0) ? 9'd511 : 9'($urandom_range(0, 511));
      rdy4 = ($urandom_range(0, 2) != 0);
      v1 = 1'($urandom_range(0, 1));
      r1 = ($urandom_range(0, 3) == 0) ? 9'd511 : 9'($urandom_range(0, 511));
      rdy1 = ($urandom_range(0, 2) != 0);
      #1;
      model_cycle(0, 4, v4, int'(r4), rdy4, ov4, ordy4, longint'(s4), longint'(c4));
      model_cycle(1, 1, v1, int'(r1), rdy1, ov1, ordy1, longint'(s1), longint'(c1));
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
